// File: rtl/compress_stream.sv
`default_nettype none
// ============================================================================
// Module   : compress_stream
// Function : Two-stage, valid/ready multi-lane float classifier/compressor
//            with saturating per-class lane counters.
// Revision : 1.0 - initial release
// ============================================================================
module compress_stream #(
  parameter int LANES  = 4,
  parameter int CW     = 16,
  parameter int LO_EXP = 111,
  parameter int HI_EXP = 127,
  parameter int CNT_W  = 32
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  enable,
  input  logic                  bypass,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [32*LANES-1:0]   din,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [32*LANES-1:0]   dout,
  output logic [2*LANES-1:0]    status,
  input  logic                  stat_clr,
  output logic [CNT_W-1:0]      cnt_zero,
  output logic [CNT_W-1:0]      cnt_comp,
  output logic [CNT_W-1:0]      cnt_raw
);

  localparam logic [1:0] c_ZERO = 2'b00;
  localparam logic [1:0] c_COMP = 2'b10;
  localparam logic [1:0] c_RAW  = 2'b11;

  logic                 r_s1_valid;
  logic [2*LANES-1:0]   r_s1_cls;
  logic [32*LANES-1:0]  r_s1_word;
  logic                 r_s2_valid;
  logic [32*LANES-1:0]  r_dout;
  logic [2*LANES-1:0]   r_status;
  logic [CNT_W-1:0]     r_cnt_zero;
  logic [CNT_W-1:0]     r_cnt_comp;
  logic [CNT_W-1:0]     r_cnt_raw;

  logic [2*LANES-1:0]   w_cls;
  logic [32*LANES-1:0]  w_s1d;
  logic [32*LANES-1:0]  w_s2d;
  logic                 w_s2_take;
  logic                 w_s1_adv;
  logic                 w_accept;
  logic [5:0]           w_nz;
  logic [5:0]           w_nc;
  logic [5:0]           w_nr;

  assign w_s2_take = !r_s2_valid || out_ready;
  assign w_s1_adv  = r_s1_valid && w_s2_take;
  assign in_ready  = resetn && enable && (!r_s1_valid || w_s2_take);
  assign w_accept  = in_valid && in_ready;

  genvar gi;
  generate
    for (gi = 0; gi < LANES; gi++) begin : g_lane
      logic [7:0]  w_e;
      logic [7:0]  w_sh;
      logic [23:0] w_mag;
      logic        w_s;

      assign w_e   = din[32*gi+23 +: 8];
      assign w_s   = din[32*gi+31];
      assign w_sh  = 8'(HI_EXP) - w_e;
      assign w_mag = {1'b1, din[32*gi +: 23]} >> w_sh;

      assign w_cls[2*gi +: 2] = (bypass || (w_e > 8'(HI_EXP))) ? c_RAW  :
                                (w_e <= 8'(LO_EXP))            ? c_ZERO : c_COMP;

      // Stage 1 keeps sign in bit 31 and the shifted magnitude in bits 23:0
      assign w_s1d[32*gi +: 32] = (w_cls[2*gi +: 2] == c_RAW)  ? din[32*gi +: 32] :
                                  (w_cls[2*gi +: 2] == c_COMP) ? {w_s, 7'd0, w_mag} :
                                                                 32'd0;

      assign w_s2d[32*gi +: 32] = (r_s1_cls[2*gi +: 2] == c_COMP)
          ? 32'({r_s1_word[32*gi+31], r_s1_word[32*gi+23 -: (CW-1)]})
          : r_s1_word[32*gi +: 32];
    end
  endgenerate

  always_comb begin
    w_nz = '0;
    w_nc = '0;
    w_nr = '0;
    for (int k = 0; k < LANES; k++) begin
      case (w_cls[2*k +: 2])
        c_ZERO:  w_nz = w_nz + 6'd1;
        c_COMP:  w_nc = w_nc + 6'd1;
        default: w_nr = w_nr + 6'd1;
      endcase
    end
  end

  // Wide intermediate sum so any overflow is visible before clamping
  function automatic logic [CNT_W-1:0] f_sat_add(input logic [CNT_W-1:0] a,
                                                 input logic [5:0]       b);
    logic [CNT_W+5:0] s;
    s = {6'd0, a} + {{CNT_W{1'b0}}, b};
    if (s[CNT_W+5:CNT_W] != 6'd0) return {CNT_W{1'b1}};
    return s[CNT_W-1:0];
  endfunction

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_s1_valid <= 1'b0;
      r_s1_cls   <= '0;
      r_s1_word  <= '0;
      r_s2_valid <= 1'b0;
      r_dout     <= '0;
      r_status   <= '0;
      r_cnt_zero <= '0;
      r_cnt_comp <= '0;
      r_cnt_raw  <= '0;
    end else begin
      if (w_accept) begin
        r_s1_valid <= 1'b1;
        r_s1_cls   <= w_cls;
        r_s1_word  <= w_s1d;
      end else if (w_s1_adv) begin
        r_s1_valid <= 1'b0;
      end

      if (w_s2_take) begin
        r_s2_valid <= r_s1_valid;
        if (r_s1_valid) begin
          r_dout   <= w_s2d;
          r_status <= r_s1_cls;
        end
      end

      if (stat_clr) begin
        r_cnt_zero <= '0;
        r_cnt_comp <= '0;
        r_cnt_raw  <= '0;
      end else if (w_accept) begin
        r_cnt_zero <= f_sat_add(r_cnt_zero, w_nz);
        r_cnt_comp <= f_sat_add(r_cnt_comp, w_nc);
        r_cnt_raw  <= f_sat_add(r_cnt_raw, w_nr);
      end
    end
  end

  assign out_valid = r_s2_valid;
  assign dout      = r_dout;
  assign status    = r_status;
  assign cnt_zero  = r_cnt_zero;
  assign cnt_comp  = r_cnt_comp;
  assign cnt_raw   = r_cnt_raw;

endmodule
`default_nettype wire
